ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Parametrised control-signal pipeline carrying the decoded control bundle from decode through STAGES downstream stages (E, M, W, …). Each stage has a register with valid tracking, per-stage stall (hold) and flush (bubble), and a global kill for exception or eret redirects. Each stage applies a per-stage keep-mask, so it retains only the control bits it consumes. It replaces the fixed three-register control chain, adding stalls, valid bits, automatic bubble insertion and occupancy reporting.

## Interface
Parameters:
- W, 32, width of one control bundle in bits.
- STAGES, 3, number of pipeline stages after decode; stage 0 = E, 1 = M, 2 = W; minimum 1.
- KEEP_MASK, all ones, STAGES*W bits; slice [k*W +: W] selects the bundle bits stage k keeps, and cleared bits are forced 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decode-stage bundle is a real instruction.
- in_bundle  in  W  decode-stage control bundle.
- stall  in  STAGES  stall[k]=1 holds stage k.
- flush  in  STAGES  flush[k]=1 loads a bubble into stage k.
- kill  in  1  flushes every stage in the same cycle.
- err_clr  in  1  clears stall_err.
- stage_valid  out  STAGES  valid bit of each stage register.
- stage_bundle  out  STAGES*W  stage k contents at [k*W +: W].
- occupancy  out  clog2(STAGES+1)  number of set stage_valid bits.
- stall_err  out  1  sticky; set on an illegal stall pattern.

## Operation
Reset (rst=0, asynchronous):
- All stage_valid = 0.
- All stage_bundle = 0.
- occupancy = 0.
- stall_err = 0.

Upstream of stage k:
- For stage 0: in_valid and in_bundle.
- For stage k>0: stage k-1.

Per-stage next state on each rising edge, first matching rule wins:
- kill=1 → valid 0, bundle 0 (all stages).
- flush[k]=1 → valid 0, bundle 0.
- stall[k]=1 → hold valid and bundle.
- k>0 and stall[k-1]=1 → bubble: valid 0, bundle 0. Stage k advances while its upstream holds.
- Otherwise → valid ← upstream valid, bundle ← upstream bundle & KEEP_MASK slice k.

A bubble (valid 0) always carries an all-zero bundle. Downstream write enables are therefore inert without extra gating.

Stall legality:
- stall must be monotonic toward decode: stall[k]=1 requires stall[k-1]=1 for all k≥1.
- Violation (stall[k]=1, stall[k-1]=0, no kill, no flush[k-1]): stall_err sets on that edge.
- Stage k still holds. Stage k-1 still loads from its upstream, and the instruction it held is lost; there is no correction.
- The decode-side hold when stall[0]=1 is the caller's responsibility. ctrl_pipe ignores in_* while stall[0]=1.

Error flag:
- stall_err stays set until err_clr=1.
- If err_clr and a new violation occur in the same cycle, the set wins.

occupancy is combinational from the stage_valid registers.

## Timing
- Latency: a bundle accepted at edge n appears in stage k at edge n+k, absent stalls and flushes.
- Each stall cycle on stage k adds one cycle for that bundle.
- stage_valid and stage_bundle are register outputs, with no combinational path from any input.
- occupancy is a combinational function of stage_valid only.
- kill/flush/stall take effect on the next rising edge, with no lookahead.
- flush[k] together with stall[k]: the flush wins.
- kill together with anything: kill wins, and stall_err is not set that cycle.
- Reset asserted mid-operation clears every stage immediately, without waiting for a clock edge.
- Reset release is sampled synchronously by the integrating design. The first capture happens on the first rising edge with rst=1.

## Test plan
Use W=8, STAGES=3, KEEP_MASK = {8'h0F, 8'hFF, 8'hFF} (stage 2 keeps the low nibble).
- Streaming:
  - Stimulus: bundles 8'hA1, 8'hB2, 8'hC3 with in_valid=1 on edges 1-3.
  - Required: stage0 shows A1 after edge 1.
  - Required: stage2 shows 8'h01 after edge 3 (masked), with occupancy 3 at that point.
- Stall bubble:
  - Stimulus: stall=3'b001 for 2 cycles while stage0 holds 8'h55.
  - Required: stage0 stays 55/valid.
  - Required: stage1 gets valid 0, bundle 00 on both edges.
  - Required: after release, 55 reaches stage1 one edge later.
- Flush vs stall:
  - Stimulus: flush=3'b010, stall=3'b011 on the same edge.
  - Required: stage1 becomes valid 0, bundle 00.
  - Required: stage0 holds, and stall_err stays 0.
- Kill:
  - Stimulus: kill=1 with all stages valid.
  - Required: next edge all valid=0, bundles 0, occupancy 0.
  - Required: in_valid on the same edge is discarded.
- Illegal stall:
  - Stimulus: stall=3'b010.
  - Required: stall_err=1 after the edge and stage1 holds.
  - Required: stall_err stays 1 until err_clr.
  - Required: err_clr with a simultaneous violation keeps it at 1.
- Async reset: drop rst mid-stream between edges → all outputs go to 0 before the next clk edge.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_pipe
//
// Control-signal pipeline. It carries the decoded control bundle from decode
// through STAGES downstream stages (stage 0 = E, 1 = M, 2 = W, ...).
// Each stage register has:
//   - a valid bit,
//   - a per-stage stall (hold) and a per-stage flush (bubble),
//   - a keep-mask that zeroes the bundle bits the stage does not consume.
// A global kill empties every stage. The block also reports occupancy and a
// sticky flag for stall patterns that are not monotonic toward decode.
//
// Parameters:
//   W          width of one control bundle
//   STAGES     stages after decode (>= 1)
//   KEEP_MASK  STAGES*W bits; slice [k*W +: W] is the keep-mask of stage k
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   in_valid      decode-stage bundle is a real instruction
//   in_bundle     decode-stage control bundle (W)
//   stall         per-stage hold (STAGES)
//   flush         per-stage bubble load (STAGES)
//   kill          empties every stage on the next edge
//   err_clr       clears stall_err
//   stage_valid   valid bit of each stage register (STAGES)
//   stage_bundle  stage k contents at [k*W +: W]
//   occupancy     number of valid stages (combinational from stage_valid)
//   stall_err     sticky illegal-stall flag
// ----------------------------------------------------------------------------
module ctrl_pipe #(
    parameter int                     W         = 32,
    parameter int                     STAGES    = 3,
    parameter logic [STAGES*W-1:0]    KEEP_MASK = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [W-1:0]                  in_bundle,
    input  logic [STAGES-1:0]             stall,
    input  logic [STAGES-1:0]             flush,
    input  logic                          kill,
    input  logic                          err_clr,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*W-1:0]           stage_bundle,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic                          stall_err
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]          r_valid;
    logic [STAGES-1:0][W-1:0]   r_bundle;
    logic                       r_stall_err;

    logic [STAGES-1:0]          w_up_valid;
    logic [STAGES-1:0][W-1:0]   w_up_bundle;
    logic [STAGES-1:0]          w_prev_stall;
    logic                       w_viol;
    logic [OCC_W-1:0]           w_occ;

    // Upstream view of every stage. Stage 0 is fed by decode, and stage k by
    // stage k-1. The loops start at 1, so no index ever reaches -1, and
    // STAGES=1 stays legal.
    // NOTE: every signal driven here gets a default before the loop. If a
    // path left a signal unassigned, synthesis would infer a latch.
    always_comb begin
        w_up_valid      = r_valid;
        w_up_bundle     = r_bundle;
        w_prev_stall    = '0;
        w_viol          = 1'b0;
        w_up_valid[0]   = in_valid;
        w_up_bundle[0]  = in_bundle;
        for (int k = 1; k < STAGES; k++) begin
            w_up_valid[k]   = r_valid[k-1];
            w_up_bundle[k]  = r_bundle[k-1];
            w_prev_stall[k] = stall[k-1];
            // A stage holds while its upstream advances. If the upstream is
            // not flushed, the upstream's instruction is overwritten.
            if (stall[k] && !stall[k-1] && !flush[k-1])
                w_viol = 1'b1;
        end
        // Kill empties the whole pipe, so nothing can be lost that cycle.
        if (kill)
            w_viol = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments. Every stage then
    // samples the pre-edge value of its upstream. With blocking assignments
    // a bundle would skip through several stages on one edge.
    // NOTE: every stage register is in the reset domain, not only the valid
    // bits. A bubble must carry an all-zero bundle from the first cycle on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= '0;
            r_bundle    <= '0;
            r_stall_err <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (kill || flush[k]) begin
                    r_valid[k]  <= 1'b0;
                    r_bundle[k] <= '0;
                end else if (stall[k]) begin
                    // hold: keep valid and bundle
                end else if (w_prev_stall[k]) begin
                    // Upstream is holding: move on and leave a bubble behind.
                    r_valid[k]  <= 1'b0;
                    r_bundle[k] <= '0;
                end else begin
                    r_valid[k]  <= w_up_valid[k];
                    r_bundle[k] <= w_up_bundle[k] & KEEP_MASK[k*W +: W];
                end
            end

            // If a new violation and a clear occur together, the set wins.
            if (w_viol)
                r_stall_err <= 1'b1;
            else if (err_clr)
                r_stall_err <= 1'b0;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < STAGES; k++)
            w_occ = w_occ + OCC_W'(r_valid[k]);
    end

    assign stage_valid  = r_valid;
    assign stage_bundle = r_bundle;
    assign occupancy    = w_occ;
    assign stall_err    = r_stall_err;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipe
//
// Self-checking bench for ctrl_pipe with W=8, STAGES=3 and
// KEEP_MASK={8'h0F,8'hFF,8'hFF}.
// - A behavioural model of the pipe is updated on every clock edge.
// - A compare process checks all DUT outputs against the model on each
//   falling edge.
// - The directed sequence adds literal expectations at the key points.
// ----------------------------------------------------------------------------
module tb_ctrl_pipe;

    localparam int W      = 8;
    localparam int STAGES = 3;
    localparam logic [STAGES*W-1:0] KEEP = {8'h0F, 8'hFF, 8'hFF};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [W-1:0]         in_bundle;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic                 kill;
    logic                 err_clr;
    logic [STAGES-1:0]    stage_valid;
    logic [STAGES*W-1:0]  stage_bundle;
    logic [1:0]           occupancy;
    logic                 stall_err;

    int n_vec  = 0;
    int n_miss = 0;

    ctrl_pipe #(.W(W), .STAGES(STAGES), .KEEP_MASK(KEEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_bundle    (in_bundle),
        .stall        (stall),
        .flush        (flush),
        .kill         (kill),
        .err_clr      (err_clr),
        .stage_valid  (stage_valid),
        .stage_bundle (stage_bundle),
        .occupancy    (occupancy),
        .stall_err    (stall_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] keep_of [STAGES] = '{8'hFF, 8'hFF, 8'h0F};
    logic       m_valid [STAGES] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] m_bundle[STAGES] = '{8'h00, 8'h00, 8'h00};
    logic       m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        logic       nv[STAGES];
        logic [7:0] nb[STAGES];
        logic       up_v, lost;
        logic [7:0] up_b;
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                m_valid[k]  = 1'b0;
                m_bundle[k] = 8'h00;
            end
            m_err = 1'b0;
        end else begin
            lost = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                if (k == 0) begin
                    up_v = in_valid;
                    up_b = in_bundle;
                end else begin
                    up_v = m_valid[k-1];
                    up_b = m_bundle[k-1];
                end
                // The first matching rule wins.
                if (kill || flush[k]) begin
                    nv[k] = 1'b0; nb[k] = 8'h00;
                end else if (stall[k]) begin
                    nv[k] = m_valid[k]; nb[k] = m_bundle[k];
                end else if (k > 0 && stall[k-1]) begin
                    nv[k] = 1'b0; nb[k] = 8'h00;
                end else begin
                    nv[k] = up_v; nb[k] = up_b & keep_of[k];
                end
                if (k > 0 && !kill && stall[k] && !stall[k-1] && !flush[k-1])
                    lost = 1'b1;
            end
            for (int k = 0; k < STAGES; k++) begin
                m_valid[k]  = nv[k];
                m_bundle[k] = nb[k];
            end
            if (lost)
                m_err = 1'b1;
            else if (err_clr)
                m_err = 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sb(input int k);
        return stage_bundle[k*W +: W];
    endfunction

    // Compare process: runs on every falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [2:0]  ev;
        logic [23:0] eb;
        int          cnt;
        cnt = 0;
        for (int k = 0; k < STAGES; k++) begin
            ev[k]         = m_valid[k];
            eb[k*W +: W]  = m_bundle[k];
            cnt          += int'(m_valid[k]);
        end
        check("cmp_valid",  32'(stage_valid),  32'(ev));
        check("cmp_bundle", 32'(stage_bundle), 32'(eb));
        check("cmp_occ",    32'(occupancy),    32'(cnt));
        check("cmp_err",    32'(stall_err),    32'(m_err));
    end

    // Drive one cycle of inputs and advance past the next rising edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic [2:0] st,
                       input logic [2:0] fl, input logic k, input logic ec);
        in_valid  = v;
        in_bundle = b;
        stall     = st;
        flush     = fl;
        kill      = k;
        err_clr   = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_bundle = 8'h00; stall = '0; flush = '0;
        kill = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid",  32'(stage_valid),  32'h0);
        check("rst_bundle", 32'(stage_bundle), 32'h0);
        check("rst_occ",    32'(occupancy),    32'h0);
        check("rst_err",    32'(stall_err),    32'h0);
        rst = 1'b1;

        // Streaming
        cyc(1, 8'hA1, 3'b000, 3'b000, 0, 0);
        check("stream_s0_bundle", 32'(sb(0)), 32'hA1);
        check("stream_s0_valid",  32'(stage_valid[0]), 32'h1);
        cyc(1, 8'hB2, 3'b000, 3'b000, 0, 0);
        cyc(1, 8'hC3, 3'b000, 3'b000, 0, 0);
        check("stream_s2_masked", 32'(sb(2)), 32'h01);
        check("stream_s1",        32'(sb(1)), 32'hB2);
        check("stream_occ3",      32'(occupancy), 32'h3);

        // Stall bubble: stage 0 holds 55, and the ignored in_bundle changes.
        cyc(1, 8'h55, 3'b000, 3'b000, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 8'h66, 3'b001, 3'b000, 0, 0);
            check("bub_s0_bundle", 32'(sb(0)), 32'h55);
            check("bub_s0_valid",  32'(stage_valid[0]), 32'h1);
            check("bub_s1_valid",  32'(stage_valid[1]), 32'h0);
            check("bub_s1_bundle", 32'(sb(1)), 32'h00);
        end
        cyc(1, 8'h66, 3'b000, 3'b000, 0, 0);
        check("bub_release_s1", 32'(sb(1)), 32'h55);
        check("bub_release_s0", 32'(sb(0)), 32'h66);

        // Flush together with stall: the flush wins on stage 1.
        cyc(1, 8'h77, 3'b011, 3'b010, 0, 0);
        check("fs_s1_valid",  32'(stage_valid[1]), 32'h0);
        check("fs_s1_bundle", 32'(sb(1)), 32'h00);
        check("fs_s0_hold",   32'(sb(0)), 32'h66);
        check("fs_err",       32'(stall_err), 32'h0);

        // Kill with all stages valid, plus in_valid and an illegal stall.
        cyc(1, 8'h88, 3'b000, 3'b000, 0, 0);
        cyc(1, 8'h99, 3'b000, 3'b000, 0, 0);
        check("pre_kill_occ", 32'(occupancy), 32'h3);
        check("pre_kill_s2",  32'(sb(2)), 32'h06);
        cyc(1, 8'hAA, 3'b010, 3'b000, 1, 0);
        check("kill_valid",  32'(stage_valid),  32'h0);
        check("kill_bundle", 32'(stage_bundle), 32'h0);
        check("kill_occ",    32'(occupancy),    32'h0);
        check("kill_err",    32'(stall_err),    32'h0);

        // Illegal stall
        cyc(1, 8'h11, 3'b000, 3'b000, 0, 0);
        cyc(1, 8'h22, 3'b000, 3'b000, 0, 0);
        cyc(1, 8'h33, 3'b010, 3'b000, 0, 0);
        check("ill_err_set", 32'(stall_err), 32'h1);
        check("ill_s1_hold", 32'(sb(1)), 32'h11);
        check("ill_s0_load", 32'(sb(0)), 32'h33);
        check("ill_s2_bub",  32'(stage_valid[2]), 32'h0);
        cyc(0, 8'h00, 3'b000, 3'b000, 0, 0);
        check("ill_sticky1", 32'(stall_err), 32'h1);
        check("ill_s2_after", 32'(sb(2)), 32'h01);
        cyc(0, 8'h00, 3'b000, 3'b000, 0, 0);
        check("ill_sticky2", 32'(stall_err), 32'h1);
        cyc(0, 8'h00, 3'b010, 3'b000, 0, 1);
        check("ill_clr_vs_set", 32'(stall_err), 32'h1);
        cyc(0, 8'h00, 3'b000, 3'b000, 0, 1);
        check("ill_cleared", 32'(stall_err), 32'h0);

        // Async reset mid-stream, between edges
        cyc(1, 8'h5A, 3'b000, 3'b000, 0, 0);
        cyc(1, 8'h5B, 3'b010, 3'b000, 0, 0);
        check("ar_pre_err", 32'(stall_err), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",  32'(stage_valid),  32'h0);
        check("ar_bundle", 32'(stage_bundle), 32'h0);
        check("ar_occ",    32'(occupancy),    32'h0);
        check("ar_err",    32'(stall_err),    32'h0);
        cyc(1, 8'h5C, 3'b000, 3'b000, 0, 0);
        check("ar_held", 32'(stage_valid), 32'h0);
        rst = 1'b1;
        cyc(1, 8'hC0, 3'b000, 3'b000, 0, 0);
        check("ar_first_capture", 32'(sb(0)), 32'hC0);
        cyc(0, 8'h00, 3'b000, 3'b000, 0, 0);
        cyc(0, 8'h00, 3'b000, 3'b000, 0, 0);
        check("ar_drain_s2", 32'(sb(2)), 32'h00);
        check("ar_drain_occ", 32'(occupancy), 32'h1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
